// File: rtl/axi4_slave_write_sequencer.sv
// AXI4 slave write-channel sequencer: accepts one write burst at a time,
// walks the beat addresses (FIXED/INCR/WRAP), drives a simple storage write
// port and returns a single B response (OKAY or SLVERR).
module axi4_slave_write_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [LEN_WIDTH-1:0]    AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH/8);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                state, state_next;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  err_q;
  logic                  supp_q;
  logic [1:0]            resp_q;

  logic                  aw_hs, w_hs, b_hs;
  logic                  cnt_at_len, last_beat, beat_err, aw_bad;
  logic [ADDR_WIDTH-1:0] step, incr_addr, wrap_mask, next_addr;

  assign aw_hs      = AWVALID & AWREADY;
  assign w_hs       = WVALID & WREADY;
  assign b_hs       = BVALID & BREADY;
  assign cnt_at_len = (cnt_q == len_q);
  assign last_beat  = w_hs & (WLAST | cnt_at_len);
  assign beat_err   = w_hs & (WLAST != cnt_at_len);

  // Unsupported burst attributes: reserved type, illegal wrap length, oversize beat
  assign aw_bad = (AWBURST == 2'b11)
                | ((AWBURST == 2'b10) & ~((AWLEN == LEN_WIDTH'(1)) | (AWLEN == LEN_WIDTH'(3)) |
                                          (AWLEN == LEN_WIDTH'(7)) | (AWLEN == LEN_WIDTH'(15))))
                | (32'(AWSIZE) > MAX_SIZE);

  // Address of the beat following the current one
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    incr_addr = addr_q + step;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    next_addr = addr_q;
    case (burst_q)
      2'b01:   next_addr = incr_addr;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = addr_q;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (aw_hs)     state_next = DATA;
      DATA:    if (last_beat) state_next = RESP;
      RESP:    if (b_hs)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered handshake outputs follow the state being entered
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      resp_q  <= 2'b00;
    end else begin
      AWREADY <= (state_next == IDLE);
      WREADY  <= (state_next == DATA);
      BVALID  <= (state_next == RESP);
      if (last_beat)
        resp_q <= (err_q | beat_err) ? 2'b10 : 2'b00;
      else if (b_hs)
        resp_q <= 2'b00;
    end
  end

  // Burst capture, beat counting and sticky error tracking
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      supp_q  <= 1'b0;
    end else if (aw_hs) begin
      id_q    <= AWID;
      addr_q  <= AWADDR;
      len_q   <= AWLEN;
      size_q  <= AWSIZE;
      burst_q <= AWBURST;
      cnt_q   <= '0;
      err_q   <= aw_bad;
      supp_q  <= aw_bad;
    end else if (w_hs) begin
      cnt_q  <= cnt_q + LEN_WIDTH'(1);
      addr_q <= next_addr;
      if (beat_err) err_q <= 1'b1;
    end
  end

  assign BID   = id_q;
  assign BRESP = resp_q;

  // Data and strobes are gated by WREADY so the storage port reads zero outside the data phase
  assign mem_we    = w_hs & ~supp_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = WREADY ? WDATA : '0;
  assign mem_wstrb = WREADY ? WSTRB : '0;

endmodule

// File: tb/tb_axi4_slave_write_sequencer.sv
// Directed bench for axi4_slave_write_sequencer with write/response scoreboards.
module tb_axi4_slave_write_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [3:0]  AWID;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        BVALID, BREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int n_cmp = 0;
  int n_mis = 0;

  logic [67:0] wq[$];  // {addr, data, strb}
  logic [5:0]  bq[$];  // {id, resp}

  axi4_slave_write_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the storage port against the scoreboard at the current sample point
  task automatic observe_write(input bit we);
    logic [67:0] e;
    check("mem_we", mem_we, we);
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) check("wq_underflow", 1, 0);
      else begin
        e = wq.pop_front();
        check("mem_addr",  mem_addr,  e[67:36]);
        check("mem_wdata", mem_wdata, e[35:4]);
        check("mem_wstrb", mem_wstrb, e[3:0]);
      end
    end
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] bt, input logic [1:0] resp);
    bit ok = 0;
    bq.push_back({id, resp});
    AWVALID = 1; AWADDR = a; AWID = id; AWLEN = len; AWSIZE = sz; AWBURST = bt;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      ok = (AWREADY === 1'b1);
    end
    if (!ok) check("aw_timeout", 0, 1);
    @(posedge CLK); #1;
    AWVALID = 0;
    check("awready_after_aw", AWREADY, 0);
    check("wready_after_aw",  WREADY,  1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic last,
                           input bit we, input logic [31:0] a);
    bit ok = 0;
    WVALID = 1; WDATA = d; WSTRB = s; WLAST = last;
    if (we) wq.push_back({a, d, s});
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      ok = (WREADY === 1'b1);
    end
    if (!ok) check("w_timeout", 0, 1);
    observe_write(we);
    @(posedge CLK); #1;
    WVALID = 0; WLAST = 0;
  endtask

  task automatic end_of_data;
    check("bvalid_after_last", BVALID, 1);
    check("wready_after_last", WREADY, 0);
  endtask

  task automatic b_phase(input int delay);
    logic [5:0] e;
    bit ok = 0;
    if (bq.size() == 0) begin
      check("bq_underflow", 1, 0);
      e = '0;
    end else e = bq.pop_front();
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      ok = (BVALID === 1'b1);
    end
    if (!ok) check("b_timeout", 0, 1);
    for (int i = 0; i < delay; i++) begin
      check("bvalid_hold", BVALID, 1);
      check("bid_hold",    BID,    e[5:2]);
      check("bresp_hold",  BRESP,  e[1:0]);
      check("awready_hold", AWREADY, 0);
      @(negedge CLK);
    end
    BREADY = 1;
    #1;
    check("bvalid", BVALID, 1);
    check("bid",    BID,    e[5:2]);
    check("bresp",  BRESP,  e[1:0]);
    check("awready_in_bhs", AWREADY, 0);
    @(posedge CLK); #1;
    BREADY = 0;
    check("bvalid_after_b",  BVALID,  0);
    check("awready_after_b", AWREADY, 1);
  endtask

  initial begin
    RST = 0; AWVALID = 0; AWADDR = '0; AWID = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    WVALID = 0; WDATA = '0; WSTRB = '0; WLAST = 0; BREADY = 0;
    #3;
    check("rst_awready", AWREADY, 0);
    check("rst_wready",  WREADY,  0);
    check("rst_bvalid",  BVALID,  0);
    check("rst_bid",     BID,     0);
    check("rst_bresp",   BRESP,   0);
    check("rst_mem_we",  mem_we,  0);
    check("rst_mem_addr", mem_addr, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1; #1;
    check("awready_before_edge", AWREADY, 0);
    @(posedge CLK); #1;
    check("awready_first_edge", AWREADY, 1);

    // INCR 4 beats
    do_aw(32'h100, 4'd5, 8'd3, 3'd2, 2'b01, 2'b00);
    send_beat(32'hA0A0_0001, 4'hF, 0, 1, 32'h100);
    send_beat(32'hA0A0_0002, 4'h3, 0, 1, 32'h104);
    send_beat(32'hA0A0_0003, 4'hC, 0, 1, 32'h108);
    send_beat(32'hA0A0_0004, 4'hF, 1, 1, 32'h10C);
    end_of_data();
    b_phase(0);

    // WRAP 4 beats, response held off for 5 cycles
    do_aw(32'h38, 4'd2, 8'd3, 3'd2, 2'b10, 2'b00);
    send_beat(32'hB0B0_0001, 4'hF, 0, 1, 32'h38);
    send_beat(32'hB0B0_0002, 4'hF, 0, 1, 32'h3C);
    send_beat(32'hB0B0_0003, 4'hF, 0, 1, 32'h30);
    send_beat(32'hB0B0_0004, 4'hF, 1, 1, 32'h34);
    end_of_data();
    b_phase(5);

    // Early WLAST on beat 2 of 4
    do_aw(32'h200, 4'd7, 8'd3, 3'd2, 2'b01, 2'b10);
    send_beat(32'hC0C0_0001, 4'hF, 0, 1, 32'h200);
    send_beat(32'hC0C0_0002, 4'hF, 1, 1, 32'h204);
    end_of_data();
    b_phase(1);

    // Reserved burst type: beats accepted but never written
    do_aw(32'h300, 4'd9, 8'd1, 3'd2, 2'b11, 2'b10);
    send_beat(32'hD0D0_0001, 4'hF, 0, 0, 32'h0);
    send_beat(32'hD0D0_0002, 4'hF, 1, 0, 32'h0);
    end_of_data();
    b_phase(0);

    // FIXED burst keeps the address
    do_aw(32'h40, 4'd1, 8'd1, 3'd2, 2'b00, 2'b00);
    send_beat(32'hE0E0_0001, 4'hF, 0, 1, 32'h40);
    send_beat(32'hE0E0_0002, 4'h1, 1, 1, 32'h40);
    end_of_data();
    b_phase(0);

    // Count reaches AWLEN without WLAST
    do_aw(32'h600, 4'd6, 8'd1, 3'd1, 2'b01, 2'b10);
    send_beat(32'h1111_0001, 4'h3, 0, 1, 32'h600);
    send_beat(32'h1111_0002, 4'h3, 0, 1, 32'h602);
    end_of_data();
    b_phase(0);

    // Reset during beat 2 of an 8-beat burst
    do_aw(32'h400, 4'd3, 8'd7, 3'd2, 2'b01, 2'b00);
    send_beat(32'hF0F0_0001, 4'hF, 0, 1, 32'h400);
    WVALID = 1; WDATA = 32'hF0F0_0002; WSTRB = 4'hF; WLAST = 0;
    wq.push_back({32'h404, 32'hF0F0_0002, 4'hF});
    @(negedge CLK);
    observe_write(1);
    RST = 0; #1;
    void'(bq.pop_back());
    check("mid_rst_awready", AWREADY, 0);
    check("mid_rst_wready",  WREADY,  0);
    check("mid_rst_bvalid",  BVALID,  0);
    check("mid_rst_bid",     BID,     0);
    check("mid_rst_bresp",   BRESP,   0);
    check("mid_rst_mem_we",  mem_we,  0);
    check("mid_rst_mem_addr",  mem_addr,  0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    check("mid_rst_mem_wstrb", mem_wstrb, 0);
    WVALID = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1; #1;
    check("rel_awready_pre", AWREADY, 0);
    @(posedge CLK); #1;
    check("rel_awready", AWREADY, 1);
    check("rel_bvalid",  BVALID,  0);

    do_aw(32'h500, 4'd4, 8'd1, 3'd2, 2'b01, 2'b00);
    send_beat(32'h2222_0001, 4'hF, 0, 1, 32'h500);
    send_beat(32'h2222_0002, 4'hF, 1, 1, 32'h504);
    end_of_data();
    b_phase(0);

    check("wq_empty", wq.size(), 0);
    check("bq_empty", bq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/axi4_slave_write_sequencer.md
AXI4_SLAVE_WRITE_SEQUENCER -- requirements
Module: axi4_slave_write_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write data width (8/16/32/64).
REQ-003 SHALL have parameter ID_WIDTH, default 4, transaction ID width.
REQ-004 SHALL have parameter LEN_WIDTH, default 8, burst length field width.
REQ-005 SHALL have port CLK  in  1  the single clock; all state on rising edge.
REQ-006 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports AWVALID in 1, AWREADY out 1  write address handshake.
REQ-008 SHALL have ports AWADDR in ADDR_WIDTH, AWID in ID_WIDTH, AWLEN in LEN_WIDTH, AWSIZE in 3, AWBURST in 2  write address attributes.
REQ-009 SHALL have ports WVALID in 1, WREADY out 1  write data handshake.
REQ-010 SHALL have ports WDATA in DATA_WIDTH, WSTRB in DATA_WIDTH/8, WLAST in 1  write beat payload.
REQ-011 SHALL have ports BVALID out 1, BREADY in 1, BID out ID_WIDTH, BRESP out 2  write response.
REQ-012 SHALL have ports mem_we out 1, mem_addr out ADDR_WIDTH, mem_wdata out DATA_WIDTH, mem_wstrb out DATA_WIDTH/8  storage write port.

Function
REQ-013 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE; one outstanding write at a time.
REQ-014 SHALL assert registered AWREADY only in IDLE; an AW handshake at edge N captures AWID/AWADDR/AWLEN/AWSIZE/AWBURST, clears the beat counter and error flag, and enters DATA with AWREADY=0.
REQ-015 SHALL assert registered WREADY only in DATA, starting the cycle after the AW handshake; WVALID outside DATA is ignored.
REQ-016 SHALL drive mem_we = WVALID & WREADY & ~suppress combinationally, with mem_addr = current beat address, mem_wdata = WDATA, mem_wstrb = WSTRB in that cycle.
REQ-017 SHALL advance the beat address after each accepted beat: FIXED (00) unchanged; INCR (01) addr + (1<<AWSIZE); WRAP (10) low bits wrap within aligned window of (AWLEN+1)<<AWSIZE bytes, upper bits unchanged.
REQ-018 SHALL end the data phase on the accepted beat where WLAST=1 or beat count = AWLEN, whichever comes first; WREADY drops and BVALID rises on the following cycle.
REQ-019 SHALL set the sticky error flag when WLAST and the count disagree (WLAST early, or count=AWLEN without WLAST).
REQ-020 SHALL set the error flag and set suppress (no mem_we for the whole burst, beats still accepted) for AWBURST=11, WRAP with AWLEN not in {1,3,7,15}, or AWSIZE > log2(DATA_WIDTH/8).
REQ-021 SHALL, in RESP, hold BVALID=1, BID = captured AWID, BRESP = 10 (SLVERR) if error flag else 00 (OKAY), all stable until BREADY.
REQ-022 SHALL, on B handshake at edge K, drop BVALID and return to IDLE with AWREADY=1 from K+1; no AW acceptance in the handshake cycle.
REQ-023 SHALL compute beat counter in LEN_WIDTH bits; AWLEN=255 yields 256 beats without overflow ambiguity.

Reset
REQ-024 SHALL, on RST low, immediately force IDLE, AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, clear all captured fields and flags.
REQ-025 SHALL discard any in-flight burst on reset mid-operation, issuing no B response for it.
REQ-026 SHALL assert AWREADY on the first rising CLK edge after RST goes high.

Verification
REQ-027 INCR: AWADDR=0x100, AWLEN=3, AWSIZE=2, AWID=5, 4 beats with WLAST on 4th -> mem_we at 0x100/0x104/0x108/0x10C, BVALID next cycle, BID=5, BRESP=00.
REQ-028 WRAP: AWADDR=0x38, AWLEN=3, AWSIZE=2 -> mem_addr 0x38, 0x3C, 0x30, 0x34; BRESP=00.
REQ-029 Early WLAST: AWLEN=3, WLAST on beat 2 -> 2 writes, data phase ends, BRESP=10.
REQ-030 Reserved AWBURST=11, AWLEN=1 -> 2 beats accepted, mem_we never asserted, BRESP=10.
REQ-031 BREADY held low 5 cycles -> BVALID/BID/BRESP stable 5 cycles, AWREADY=0 until cycle after BREADY=1.
REQ-032 RST low during beat 2 of AWLEN=7 -> all outputs 0 immediately, no BVALID; AWREADY=1 first edge after release; new burst completes with BRESP=00.
